// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared opcodes, reset constants and fetch control bundle.
//  Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam int PC_W = 32;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_JAL   = 6'b000011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_BNE   = 6'b000101;
    localparam logic [5:0] NOP_OPC   = 6'b100000;

    localparam logic [31:0] NOP_INSTR = {NOP_OPC, 26'd0};
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    // Redirect/stall controls arriving from decode and the hazard unit.
    typedef struct packed {
        logic flush;
        logic pcsrc;
        logic to_pc_2;
        logic stall;
    } redirect_t;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/next_pc_sel.sv
`default_nettype none
// ============================================================================
//  Module   : next_pc_sel
//  Brief    : Branch/jump target adder and next-PC priority mux.
//  Revision : 1.0
// ============================================================================
module next_pc_sel #(
    parameter int PC_W = 32
) (
    input  cpu_pkg::redirect_t i_ctrl,
    input  logic [PC_W-1:0]    i_pc,
    input  logic [PC_W-1:0]    i_ifid_pc4,
    input  logic [25:0]        i_ifid_index,
    input  logic [PC_W-1:0]    i_jr_target,
    output logic [PC_W-1:0]    o_next_pc,
    output logic [PC_W-1:0]    o_pc_plus4
);
    import cpu_pkg::*;

    logic [PC_W-1:0] w_br_offset;
    logic [PC_W-1:0] w_br_target;
    logic [PC_W-1:0] w_j_target;

    always_comb begin
        w_br_offset = {{(PC_W-18){i_ifid_index[15]}}, i_ifid_index[15:0], 2'b00};
        w_br_target = i_ifid_pc4 + w_br_offset;
        w_j_target  = {i_ifid_pc4[PC_W-1:28], i_ifid_index, 2'b00};
        o_pc_plus4  = i_pc + {{(PC_W-3){1'b0}}, 3'd4};

        // Redirects outrank the stall so a squash is never lost behind a hold.
        o_next_pc = o_pc_plus4;
        if (i_ctrl.flush && i_ctrl.pcsrc) begin
            o_next_pc = w_br_target;
        end else if (i_ctrl.flush && i_ctrl.to_pc_2) begin
            o_next_pc = w_j_target;
        end else if (i_ctrl.flush) begin
            o_next_pc = i_jr_target;
        end else if (i_ctrl.stall) begin
            o_next_pc = i_pc;
        end
    end

endmodule : next_pc_sel
`default_nettype wire

// File: rtl/if_stage_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : if_stage_fetch
//  Brief    : Instruction fetch, PC steering and IF/ID pipeline register.
//  Revision : 1.0
// ============================================================================
module if_stage_fetch #(
    parameter int              PC_W      = 32,
    parameter logic [PC_W-1:0] RESET_PC  = cpu_pkg::RESET_PC,
    parameter logic [31:0]     NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     imem_instr,
    output logic [PC_W-1:0] imem_addr,
    input  logic            Stall,
    input  logic            FlushFlag,
    input  logic            PCsrc,
    input  logic            toPC_2,
    input  logic [PC_W-1:0] jr_target,
    output logic [31:0]     IFID_instr,
    output logic [PC_W-1:0] IFID_pc4,
    output logic            IFID_valid,
    output logic [15:0]     redirect_cnt
);
    import cpu_pkg::*;

    redirect_t       w_ctrl;
    logic [PC_W-1:0] w_next_pc;
    logic [PC_W-1:0] w_pc_plus4;

    logic [PC_W-1:0] r_pc_q;
    logic [PC_W-1:0] w_pc_d;
    logic [31:0]     r_ifid_instr_q;
    logic [31:0]     w_ifid_instr_d;
    logic [PC_W-1:0] r_ifid_pc4_q;
    logic [PC_W-1:0] w_ifid_pc4_d;
    logic            r_ifid_valid_q;
    logic            w_ifid_valid_d;
    logic [15:0]     r_redirect_cnt_q;
    logic [15:0]     w_redirect_cnt_d;

    always_comb begin
        w_ctrl.flush   = FlushFlag;
        w_ctrl.pcsrc   = PCsrc;
        w_ctrl.to_pc_2 = toPC_2;
        w_ctrl.stall   = Stall;
    end

    next_pc_sel #(
        .PC_W (PC_W)
    ) u_next_pc_sel (
        .i_ctrl       (w_ctrl),
        .i_pc         (r_pc_q),
        .i_ifid_pc4   (r_ifid_pc4_q),
        .i_ifid_index (r_ifid_instr_q[25:0]),
        .i_jr_target  (jr_target),
        .o_next_pc    (w_next_pc),
        .o_pc_plus4   (w_pc_plus4)
    );

    always_comb begin
        w_pc_d           = w_next_pc;
        w_ifid_instr_d   = r_ifid_instr_q;
        w_ifid_pc4_d     = r_ifid_pc4_q;
        w_ifid_valid_d   = r_ifid_valid_q;
        w_redirect_cnt_d = r_redirect_cnt_q;

        // The word fetched alongside a redirect is on the wrong path: replace it.
        if (FlushFlag) begin
            w_ifid_instr_d = NOP_INSTR;
            w_ifid_pc4_d   = '0;
            w_ifid_valid_d = 1'b0;
        end else if (!Stall) begin
            w_ifid_instr_d = imem_instr;
            w_ifid_pc4_d   = w_pc_plus4;
            w_ifid_valid_d = 1'b1;
        end

        if (FlushFlag && (r_redirect_cnt_q != 16'hFFFF)) begin
            w_redirect_cnt_d = r_redirect_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_q           <= RESET_PC;
            r_ifid_instr_q   <= NOP_INSTR;
            r_ifid_pc4_q     <= '0;
            r_ifid_valid_q   <= 1'b0;
            r_redirect_cnt_q <= 16'd0;
        end else begin
            r_pc_q           <= w_pc_d;
            r_ifid_instr_q   <= w_ifid_instr_d;
            r_ifid_pc4_q     <= w_ifid_pc4_d;
            r_ifid_valid_q   <= w_ifid_valid_d;
            r_redirect_cnt_q <= w_redirect_cnt_d;
        end
    end

    assign imem_addr    = r_pc_q;
    assign IFID_instr   = r_ifid_instr_q;
    assign IFID_pc4     = r_ifid_pc4_q;
    assign IFID_valid   = r_ifid_valid_q;
    assign redirect_cnt = r_redirect_cnt_q;

endmodule : if_stage_fetch
`default_nettype wire

// File: doc/if_stage_fetch.md
Name: if_stage_fetch

Overview:
- Instruction-fetch stage and IF/ID pipeline register of the pipelined processor.
- It is the consumer of the decode-stage control outputs: it acts on PCsrc, toPC_2 and FlushFlag to steer the PC.
- It computes branch and jump targets from the instruction currently held in IF/ID.
- It honours a hazard-unit stall and squashes the fetched instruction into a nop on a redirect.

Parameters:
- PC_W, 32, PC and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h8000_0000, instruction word inserted on flush or reset. Its opcode is 6'b100000 and all other fields are zero.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- imem_instr  in  32  instruction word from instruction memory. Combinational read at imem_addr.
- imem_addr  out  PC_W  current PC presented to instruction memory.
- Stall  in  1  hazard unit: hold PC and IF/ID.
- FlushFlag  in  1  decode stage: redirect fetch and squash the fetched instruction.
- PCsrc  in  1  taken-branch select, valid with FlushFlag.
- toPC_2  in  1  1 = immediate jump (j/jal), 0 = register jump (jr). Only meaningful when FlushFlag=1 and PCsrc=0.
- jr_target  in  PC_W  forwarded rs value for jr.
- IFID_instr  out  32  registered instruction to decode.
- IFID_pc4  out  PC_W  registered PC+4 of IFID_instr.
- IFID_valid  out  1  0 when IF/ID holds a squash or reset bubble.
- redirect_cnt  out  16  count of applied redirects; saturates at 16'hFFFF.

Behaviour:
Reset (rst=1 at a clock edge), regardless of all other inputs:
- pc = RESET_PC.
- IFID_instr = NOP_INSTR.
- IFID_pc4 = 0.
- IFID_valid = 0.
- redirect_cnt = 0.

imem_addr = pc, combinationally. Fetch latency is 1 cycle: the word at pc appears on IFID_instr after the next edge.

Target computation, combinational from the IF/ID contents:
- br_target = IFID_pc4 + ({{14{IFID_instr[15]}}, IFID_instr[15:0]} << 2). Modulo 2^32; wrap-around is ignored.
- j_target = {IFID_pc4[31:28], IFID_instr[25:0], 2'b00}.

Next-PC priority, highest first:
1. FlushFlag=1 and PCsrc=1: br_target.
2. FlushFlag=1 and toPC_2=1: j_target.
3. FlushFlag=1: jr_target.
4. Stall=1: pc (hold).
5. Otherwise: pc+4.

IF/ID update at each edge:
- FlushFlag=1: IFID_instr = NOP_INSTR, IFID_pc4 = 0, IFID_valid = 0. Flush wins over a simultaneous Stall.
- Stall=1 (no flush): all IF/ID fields hold.
- Otherwise: IFID_instr = imem_instr, IFID_pc4 = pc+4, IFID_valid = 1.

Redirect counter:
- redirect_cnt increments on every edge with FlushFlag=1 and rst=0.
- It holds at 16'hFFFF once saturated.

Edge rules:
- PCsrc=1 with FlushFlag=0 is ignored.
- A flush while IFID_valid=0 still redirects, using the bubble's target fields. The decode stage never flushes on a nop, so this is benign.
- Misaligned targets (low bits not 00) are passed through unchanged.
- A reset asserted mid-stall or mid-flush takes effect immediately on that edge.

Decomposition:
- Shared package cpu_pkg:
  - opcode constants, including NOP_OPC = 6'b100000;
  - NOP_INSTR;
  - RESET_PC;
  - the PC_W localparam.
- One sub-module, next_pc_sel: a purely combinational target adder plus priority mux. The PC register, IF/ID register and counter stay in if_stage_fetch.

Test Plan:
1. Reset, then release with no stall or flush → imem_addr steps 0, 4, 8, 12. IFID_pc4 trails by one cycle at 4, 8, 12. IFID_valid goes 0 then 1.
2. IFID_instr = beq with imm 16'hFFFE and IFID_pc4 = 32'h20; drive FlushFlag=1, PCsrc=1 → next imem_addr = 32'h18, IFID_instr = 32'h8000_0000, IFID_valid=0, redirect_cnt=1.
3. IFID_instr = j with field 26'h000_0040 and IFID_pc4 = 32'h1000_0010; drive FlushFlag=1, toPC_2=1 → next pc = 32'h1000_0100.
4. FlushFlag=1, toPC_2=0, jr_target = 32'h0000_0abc → next pc = 32'h0000_0abc.
5. Stall=1 for 3 cycles at pc = 32'h40 → pc and IF/ID frozen. Then assert Stall and a FlushFlag+PCsrc redirect in the same cycle → the flush takes effect and IF/ID becomes the nop.
6. Force redirect_cnt to 16'hFFFE, then apply 3 flushes → reads FFFF and stays there. Then assert rst during a Stall → pc = 0, all outputs at their reset values on that edge.
